mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter and access sequencer in front of the load/store unit driving the SRAM.
- Requester 0 is the pipeline load/store path. Requester 1 is the switch configuration/table path.
- Grants one access at a time with round-robin fairness and holds the request for a fixed SRAM access window.
- Returns read data and an ack pulse to the winning requester, and rejects illegal width/alignment combinations without touching memory.

Parameters:
- WAIT_CYCLES, 2, cycles mem_ce is held per access; legal range 1..15.
- CNT_W, 4, width of the access-window counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- p0_req / p1_req  in  1  access request; held high with stable fields until the matching ack.
- p0_we / p1_we  in  1  1 = store, 0 = load.
- p0_addr / p1_addr  in  32  byte address (`ADDR_BUS).
- p0_width / p1_width  in  4  access size: 4'h1 byte, 4'h2 half, 4'h4 word.
- p0_wdata / p1_wdata  in  32  store data (`DATA_BUS).
- p0_ack / p1_ack  out  1  one-cycle completion pulse.
- p0_err / p1_err  out  1  valid with ack; request was rejected.
- p0_rdata / p1_rdata  out  32  load result; valid while ack is high.
- mem_ce  out  1  to load/store unit chip enable.
- mem_we  out  1  to load/store unit write enable.
- mem_addr  out  32  to load/store unit address.
- mem_width  out  4  to load/store unit width.
- mem_wdata  out  32  to load/store unit store data.
- mem_rdata  in  32  load data from load/store unit.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0, last_grant=1 (so port 0 wins first).
  - All outputs 0 / `ZERO_WORD.
  - Any in-flight access is abandoned with no ack.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Samples p0_req and p1_req. If only one is high, that port wins.
  - If both are high, the port not equal to last_grant wins. last_grant is then updated.
  - The winner's we/addr/width/wdata are registered into the mem_* output registers.
  - Legality check on the winner:
    - width must be 1, 2 or 4;
    - width 2 requires addr[0]=0;
    - width 4 requires addr[1:0]=0.
  - Legal: mem_ce=1, counter=WAIT_CYCLES-1, go to ACCESS.
  - Illegal: mem_ce stays 0, err flag set, go to DONE.
- ACCESS:
  - mem_ce and all mem_* fields are held stable.
  - While counter≠0: decrement.
  - When counter=0:
    - for a load, capture mem_rdata into the granted port's rdata register; for a store, load rdata with `ZERO_WORD;
    - mem_ce=0, mem_we=0, go to DONE.
- DONE:
  - Granted port's ack=1 for exactly one cycle; err reflects the legality result.
  - The other port's ack/err stay 0. rdata registers hold their value until the next capture.
  - Always returns to IDLE. Requests are not sampled in DONE.
- Timing:
  - Legal access: mem_ce high for exactly WAIT_CYCLES cycles starting the cycle after grant. Ack is high in cycle WAIT_CYCLES+1 after the grant edge.
  - Back-to-back throughput: one access per WAIT_CYCLES+2 cycles.
  - Illegal access: ack+err one cycle after the grant edge; mem_ce is never asserted.
- Requester rules:
  - Requester drops req on the cycle it sees ack.
  - Changes to a non-granted port's fields are ignored.
  - Deasserting req mid-access does not abort the access; ack still fires.
- mem_* outputs are registered (no combinational path from p*_ inputs). They return to 0 in IDLE and DONE except as loaded at grant.
- Starvation bound: a port holding req is granted within one competing access.

Decomposition:
- Shared def.v: `TRUE/`FALSE, `ZERO_WORD, `ADDR_BUS, `DATA_BUS, width codes (WIDTH_B=4'h1, WIDTH_H=4'h2, WIDTH_W=4'h4), and FSM state encodings (IDLE/ACCESS/DONE, 2 bits).
- No sub-module required. The legality check may be a local function.
- Integration: instantiated directly in front of the load/store unit, with mem_* wired to its ce/we/addr_i/width_i/data_i/data_o.

Test Plan:
- Reset mid-ACCESS:
  - Stimulus: p0 word load to 0x100 in progress, rst_n pulsed low.
  - Required: mem_ce=0 and all acks 0 immediately (async). After release, port 0 wins a simultaneous p0/p1 request.
- Single load, WAIT_CYCLES=2:
  - Stimulus: p0 word load, addr=0x00000010, mem_rdata=0xDEADBEEF.
  - Required: mem_ce high 2 cycles; p0_ack high on cycle 3 after the grant edge with p0_rdata=0xDEADBEEF, p0_err=0.
- Contention fairness:
  - Stimulus: p0 and p1 requesting continuously for 4 accesses.
  - Required: grants alternate p0,p1,p0,p1; each access spans 4 cycles; acks never overlap.
- Illegal requests:
  - Stimulus: p1 half store to addr 0x3, then p1 width=4'h3.
  - Required: each gets p1_ack=1, p1_err=1 one cycle after grant; mem_ce never asserted.
- Store passthrough:
  - Stimulus: p1 byte store, addr=0x22, wdata=0x000000A5.
  - Required: mem_we=1, mem_width=4'h1, mem_addr=0x22, mem_wdata=0x000000A5 stable for all WAIT_CYCLES; p1_rdata=0 at ack.
- req withdrawn mid-access:
  - Stimulus: p0 drops req during ACCESS.
  - Required: access completes and p0_ack still pulses once.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port SRAM access arbiter: bus widths, width
// codes, FSM state encoding and the width/alignment legality check.
package mem_arbiter_pkg;

  localparam int ADDR_BUS = 32;
  localparam int DATA_BUS = 32;

  localparam logic [DATA_BUS-1:0] ZERO_WORD = '0;

  localparam logic [3:0] WIDTH_B = 4'h1;
  localparam logic [3:0] WIDTH_H = 4'h2;
  localparam logic [3:0] WIDTH_W = 4'h4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Halfwords must be even-aligned and words 4-byte aligned; other widths are rejected.
  function automatic logic access_legal(input logic [3:0] width, input logic [1:0] addr_lo);
    logic ok;
    case (width)
      WIDTH_B: ok = 1'b1;
      WIDTH_H: ok = (addr_lo[0] == 1'b0);
      WIDTH_W: ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the pipeline LSU path (port 0) and the switch
// config path (port 1), sequencing one fixed-length SRAM access at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                p0_req,
  input  logic                p0_we,
  input  logic [ADDR_BUS-1:0] p0_addr,
  input  logic [3:0]          p0_width,
  input  logic [DATA_BUS-1:0] p0_wdata,
  output logic                p0_ack,
  output logic                p0_err,
  output logic [DATA_BUS-1:0] p0_rdata,

  input  logic                p1_req,
  input  logic                p1_we,
  input  logic [ADDR_BUS-1:0] p1_addr,
  input  logic [3:0]          p1_width,
  input  logic [DATA_BUS-1:0] p1_wdata,
  output logic                p1_ack,
  output logic                p1_err,
  output logic [DATA_BUS-1:0] p1_rdata,

  output logic                mem_ce,
  output logic                mem_we,
  output logic [ADDR_BUS-1:0] mem_addr,
  output logic [3:0]          mem_width,
  output logic [DATA_BUS-1:0] mem_wdata,
  input  logic [DATA_BUS-1:0] mem_rdata
);

  state_t              state, state_next;
  logic [CNT_W-1:0]    counter, counter_next;
  logic                last_grant, last_grant_next;
  logic                grant, grant_next;
  logic [1:0]          ack_q, ack_next;
  logic [1:0]          err_q, err_next;
  logic [DATA_BUS-1:0] rdata0_next, rdata1_next;

  logic                mem_ce_next, mem_we_next;
  logic [ADDR_BUS-1:0] mem_addr_next;
  logic [3:0]          mem_width_next;
  logic [DATA_BUS-1:0] mem_wdata_next;

  logic                win;
  logic                win_we;
  logic [ADDR_BUS-1:0] win_addr;
  logic [3:0]          win_width;
  logic [DATA_BUS-1:0] win_wdata;

  assign p0_ack = ack_q[0];
  assign p1_ack = ack_q[1];
  assign p0_err = err_q[0];
  assign p1_err = err_q[1];

  // A lone requester wins outright; on contention the port that did not win last time goes.
  always_comb begin
    win = ~last_grant;
    if (p0_req ^ p1_req) win = p1_req;
    win_we    = win ? p1_we    : p0_we;
    win_addr  = win ? p1_addr  : p0_addr;
    win_width = win ? p1_width : p0_width;
    win_wdata = win ? p1_wdata : p0_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next      = state;
    counter_next    = counter;
    last_grant_next = last_grant;
    grant_next      = grant;
    ack_next        = 2'b00;
    err_next        = 2'b00;
    rdata0_next     = p0_rdata;
    rdata1_next     = p1_rdata;
    mem_ce_next     = mem_ce;
    mem_we_next     = mem_we;
    mem_addr_next   = mem_addr;
    mem_width_next  = mem_width;
    mem_wdata_next  = mem_wdata;

    case (state)
      IDLE: begin
        mem_ce_next    = 1'b0;
        mem_we_next    = 1'b0;
        mem_addr_next  = '0;
        mem_width_next = '0;
        mem_wdata_next = ZERO_WORD;
        if (p0_req || p1_req) begin
          grant_next      = win;
          last_grant_next = win;
          mem_we_next     = win_we;
          mem_addr_next   = win_addr;
          mem_width_next  = win_width;
          mem_wdata_next  = win_wdata;
          if (access_legal(win_width, win_addr[1:0])) begin
            mem_ce_next  = 1'b1;
            counter_next = CNT_W'(WAIT_CYCLES - 1);
            state_next   = ACCESS;
          end else begin
            ack_next[win] = 1'b1;
            err_next[win] = 1'b1;
            state_next    = DONE;
          end
        end
      end

      ACCESS: begin
        if (counter != '0) begin
          counter_next = counter - 1'b1;
        end else begin
          if (grant) rdata1_next = mem_we ? ZERO_WORD : mem_rdata;
          else       rdata0_next = mem_we ? ZERO_WORD : mem_rdata;
          ack_next[grant] = 1'b1;
          mem_ce_next     = 1'b0;
          mem_we_next     = 1'b0;
          mem_addr_next   = '0;
          mem_width_next  = '0;
          mem_wdata_next  = ZERO_WORD;
          state_next      = DONE;
        end
      end

      DONE: begin
        mem_ce_next    = 1'b0;
        mem_we_next    = 1'b0;
        mem_addr_next  = '0;
        mem_width_next = '0;
        mem_wdata_next = ZERO_WORD;
        state_next     = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  // Reset abandons any in-flight access; last_grant=1 lets port 0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter    <= '0;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      ack_q      <= 2'b00;
      err_q      <= 2'b00;
      p0_rdata   <= ZERO_WORD;
      p1_rdata   <= ZERO_WORD;
      mem_ce     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_width  <= '0;
      mem_wdata  <= ZERO_WORD;
    end else begin
      counter    <= counter_next;
      last_grant <= last_grant_next;
      grant      <= grant_next;
      ack_q      <= ack_next;
      err_q      <= err_next;
      p0_rdata   <= rdata0_next;
      p1_rdata   <= rdata1_next;
      mem_ce     <= mem_ce_next;
      mem_we     <= mem_we_next;
      mem_addr   <= mem_addr_next;
      mem_width  <= mem_width_next;
      mem_wdata  <= mem_wdata_next;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, contention fairness, a vector table of
// single-port accesses, and a withdrawn-request sequence.
module tb_mem_arbiter;

  localparam int WAIT_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
  logic [3:0]  p0_width = 0, p1_width = 0;
  logic [31:0] mem_rdata = 0;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_ce, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_width;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  width;
    logic [31:0] wdata;
    logic [31:0] mem_rdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[11];

  mem_arbiter #(.WAIT_CYCLES(WAIT_CYCLES), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_width(p0_width),
    .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_width(p1_width),
    .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_width(mem_width),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drives one single-port request at a negedge and follows it to its ack.
  task automatic applyStimulus(input int idx, input vec_t v);
    int    ack_cyc = 0;
    int    ce_cnt = 0;
    logic  other_ack = 0;
    logic  fields_ok = 1;
    logic  got_err = 0;
    logic [31:0] got_rdata = 0;
    int    exp_ack_cyc;
    int    exp_ce;

    @(negedge clk);
    mem_rdata = v.mem_rdata;
    if (v.port) begin
      p1_we = v.we; p1_addr = v.addr; p1_width = v.width; p1_wdata = v.wdata; p1_req = 1;
    end else begin
      p0_we = v.we; p0_addr = v.addr; p0_width = v.width; p0_wdata = v.wdata; p0_req = 1;
    end

    for (int c = 1; c <= 12 && ack_cyc == 0; c++) begin
      @(negedge clk);
      if (mem_ce) begin
        ce_cnt++;
        if (mem_we !== v.we || mem_addr !== v.addr || mem_width !== v.width || mem_wdata !== v.wdata)
          fields_ok = 0;
      end
      if (v.port ? p0_ack : p1_ack) other_ack = 1;
      if (v.port ? p1_ack : p0_ack) begin
        ack_cyc   = c;
        got_err   = v.port ? p1_err : p0_err;
        got_rdata = v.port ? p1_rdata : p0_rdata;
        p0_req = 0; p1_req = 0;
      end
    end
    p0_req = 0; p1_req = 0;

    exp_ack_cyc = v.exp_err ? 1 : WAIT_CYCLES + 1;
    exp_ce      = v.exp_err ? 0 : WAIT_CYCLES;
    checkOutput($sformatf("vec%0d ack_cycle", idx), ack_cyc, exp_ack_cyc);
    checkOutput($sformatf("vec%0d ce_cycles", idx), ce_cnt, exp_ce);
    checkOutput($sformatf("vec%0d err", idx), {31'd0, got_err}, {31'd0, v.exp_err});
    checkOutput($sformatf("vec%0d rdata", idx), got_rdata, v.exp_rdata);
    checkOutput($sformatf("vec%0d other_ack", idx), {31'd0, other_ack}, 32'd0);
    if (!v.exp_err)
      checkOutput($sformatf("vec%0d mem_fields_stable", idx), {31'd0, fields_ok}, 32'd1);
  endtask

  initial begin
    int ack_port[4];
    int ack_time[4];
    int n_acks;
    int cyc;
    int wd_acks;
    logic overlap;

    vecs[0]  = '{1'b0, 1'b0, 32'h10, 4'h4, 32'h0,        32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 1'b0, 32'h22, 4'h2, 32'h0,        32'h1234ABCD, 1'b0, 32'h1234ABCD};
    vecs[2]  = '{1'b1, 1'b1, 32'h3,  4'h2, 32'h5555,     32'h0,        1'b1, 32'h1234ABCD};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,  4'h3, 32'h0,        32'h0,        1'b1, 32'h1234ABCD};
    vecs[4]  = '{1'b0, 1'b0, 32'h7,  4'h1, 32'h0,        32'h000000FF, 1'b0, 32'h000000FF};
    vecs[5]  = '{1'b0, 1'b0, 32'h2,  4'h4, 32'h0,        32'hAAAAAAAA, 1'b1, 32'h000000FF};
    vecs[6]  = '{1'b1, 1'b1, 32'h22, 4'h1, 32'h000000A5, 32'hFFFFFFFF, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 32'h40, 4'h4, 32'h0BADF00D, 32'h77777777, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 32'h4,  4'h0, 32'h0,        32'h0,        1'b1, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 32'h6,  4'h2, 32'h0,        32'hCAFE0000, 1'b0, 32'hCAFE0000};
    vecs[10] = '{1'b0, 1'b0, 32'h5,  4'h2, 32'h0,        32'h0,        1'b1, 32'h0};

    $display("[TB] reset state");
    #1;
    checkOutput("reset mem_ce", {31'd0, mem_ce}, 32'd0);
    checkOutput("reset mem_addr", mem_addr, 32'd0);
    checkOutput("reset acks", {30'd0, p1_ack, p0_ack}, 32'd0);
    checkOutput("reset p0_rdata", p0_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    $display("[TB] reset in the middle of an access");
    @(negedge clk);
    p0_we = 0; p0_addr = 32'h100; p0_width = 4'h4; p0_req = 1;
    @(negedge clk);
    checkOutput("mid-access mem_ce", {31'd0, mem_ce}, 32'd1);
    #2 rst_n = 0;
    #1;
    checkOutput("async reset mem_ce", {31'd0, mem_ce}, 32'd0);
    checkOutput("async reset acks", {30'd0, p1_ack, p0_ack}, 32'd0);
    checkOutput("async reset mem_addr", mem_addr, 32'd0);

    $display("[TB] contention fairness");
    @(negedge clk);
    rst_n = 1;
    mem_rdata = 32'h11111111;
    p1_we = 0; p1_addr = 32'h200; p1_width = 4'h4; p1_req = 1;
    n_acks = 0; overlap = 0;
    for (int c = 1; c <= 40 && n_acks < 4; c++) begin
      @(negedge clk);
      if (p0_ack && p1_ack) overlap = 1;
      if (p0_ack || p1_ack) begin
        ack_port[n_acks] = p1_ack ? 1 : 0;
        ack_time[n_acks] = c;
        n_acks++;
      end
    end
    p0_req = 0; p1_req = 0;
    checkOutput("contention ack count", n_acks, 4);
    checkOutput("contention overlap", {31'd0, overlap}, 32'd0);
    if (n_acks == 4) begin
      checkOutput("contention first ack cycle", ack_time[0], WAIT_CYCLES + 1);
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("contention grant%0d port", i), ack_port[i], i % 2);
        if (i > 0)
          checkOutput($sformatf("contention period%0d", i), ack_time[i] - ack_time[i-1], WAIT_CYCLES + 2);
      end
    end

    $display("[TB] vector table");
    for (int i = 0; i < 11; i++) applyStimulus(i, vecs[i]);

    $display("[TB] request withdrawn mid-access");
    @(negedge clk);
    mem_rdata = 32'h55AA55AA;
    p0_we = 0; p0_addr = 32'h30; p0_width = 4'h4; p0_req = 1;
    @(negedge clk);
    p0_req = 0;
    wd_acks = 0; cyc = 0;
    for (int c = 2; c <= 10; c++) begin
      @(negedge clk);
      if (p0_ack) begin
        wd_acks++;
        cyc = c;
        checkOutput("withdrawn rdata", p0_rdata, 32'h55AA55AA);
      end
    end
    checkOutput("withdrawn ack count", wd_acks, 1);
    checkOutput("withdrawn ack cycle", cyc, WAIT_CYCLES + 1);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
